byte_word_packer: RTL

//  Upstream neighbour of the sequence parser. Takes a byte-serial packet stream, packs it MSB-first into 32-bit words, and marks the last word.
//  The end of packet is found from the 16-bit length field in the header: bytes 0-1, big-endian, total bytes including the 8-byte header.

---
 rtl/byte_word_packer_if.sv | 20 ++
 rtl/byte_word_packer.sv | 87 ++++++++
 2 files changed

// File: rtl/byte_word_packer_if.sv
// byte_word_packer_if: byte-stream input and word-stream output of the packer.
interface byte_word_packer_if;
  logic [7:0]  byteIn;
  logic        byteIn_val;
  logic        byteIn_ready;
  logic [31:0] dataOut;
  logic        dataOut_val;
  logic        dataOut_ready;
  logic        dataOut_last;
  logic        lenError;
  logic [15:0] pktCount;
  modport master (
    output byteIn, byteIn_val, dataOut_ready,
    input  byteIn_ready, dataOut, dataOut_val, dataOut_last, lenError, pktCount
  );
  modport slave (
    input  byteIn, byteIn_val, dataOut_ready,
    output byteIn_ready, dataOut, dataOut_val, dataOut_last, lenError, pktCount
  );
endinterface

// File: rtl/byte_word_packer.sv
// byte_word_packer: packs a length-delimited byte stream MSB-first into 32-bit words,
// flagging the final word of each packet and out-of-range length fields.
module byte_word_packer #(
  parameter int MAX_LEN = 44,
  parameter int MIN_LEN = 8
) (
  input logic clk,
  input logic reset_b,
  byte_word_packer_if.slave bus
);
  typedef enum logic [1:0] {LEN_HI, LEN_LO, BODY} state_t;
  state_t      state;
  logic [1:0]  lane;
  logic [31:0] assembly;
  logic [7:0]  lenHi;
  logic [15:0] bytesLeft;
  logic        outFree, finalByte, complete, accept, wordTaken, lenBad;
  logic [15:0] lenFull, lenClamp;
  logic [31:0] merged;
  assign outFree   = !bus.dataOut_val || bus.dataOut_ready;
  assign finalByte = state == BODY && bytesLeft == 16'd1;
  assign complete  = lane == 2'd3 || finalByte;
  // Held low during reset so nothing is accepted while the datapath is cleared.
  assign bus.byteIn_ready = reset_b && (!complete || outFree);
  assign accept    = bus.byteIn_val && bus.byteIn_ready;
  assign wordTaken = bus.dataOut_val && bus.dataOut_ready;
  assign lenFull   = {lenHi, bus.byteIn};
  assign lenBad    = lenFull < 16'(MIN_LEN) || lenFull > 16'(MAX_LEN);
  assign lenClamp  = lenFull < 16'(MIN_LEN) ? 16'(MIN_LEN) :
                     lenFull > 16'(MAX_LEN) ? 16'(MAX_LEN) : lenFull;
  // Lanes not yet written are zero, so OR-ing the byte into its lane also pads the tail.
  assign merged    = assembly | ({bus.byteIn, 24'd0} >> {lane, 3'b000});
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state            <= LEN_HI;
      lane             <= 2'd0;
      assembly         <= 32'd0;
      lenHi            <= 8'd0;
      bytesLeft        <= 16'd0;
      bus.dataOut      <= 32'd0;
      bus.dataOut_val  <= 1'b0;
      bus.dataOut_last <= 1'b0;
      bus.lenError     <= 1'b0;
      bus.pktCount     <= 16'd0;
    end else begin
      if (accept && complete) begin
        bus.dataOut      <= merged;
        bus.dataOut_val  <= 1'b1;
        bus.dataOut_last <= finalByte;
        assembly         <= 32'd0;
        lane             <= 2'd0;
      end else begin
        if (accept) begin
          assembly <= merged;
          lane     <= lane + 2'd1;
        end
        if (wordTaken) begin
          bus.dataOut_val  <= 1'b0;
          bus.dataOut_last <= 1'b0;
        end
      end
      if (accept) begin
        case (state)
          LEN_HI: begin
            lenHi <= bus.byteIn;
            state <= LEN_LO;
          end
          LEN_LO: begin
            bytesLeft <= lenClamp - 16'd2;
            state     <= BODY;
          end
          default: begin
            bytesLeft <= bytesLeft - 16'd1;
            state     <= finalByte ? LEN_HI : BODY;
          end
        endcase
      end
      // A new error flagged on the same edge as the previous packet's last word wins.
      if (accept && state == LEN_LO && lenBad)
        bus.lenError <= 1'b1;
      else if (wordTaken && bus.dataOut_last)
        bus.lenError <= 1'b0;
      if (wordTaken && bus.dataOut_last)
        bus.pktCount <= bus.pktCount + 16'd1;
    end
  end
endmodule
